fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the program memory. It generates the 10-bit pc that the memory samples. It tracks the memory's one-cycle registered read latency and buffers returned words through a 2-entry skid path so decode can stall without losing instructions. It also handles redirects, the halt word, and, optionally, early resolution of jumps at fetch.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_skid_buffer.sv | 46 ++++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage: default widths, the halt
// marker and the jump predecode field layout.
package fetch_pkg;

  localparam int DEFAULT_PC_W    = 10;
  localparam int DEFAULT_INSTR_W = 32;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [3:0]  OP_JUMP   = 4'hC;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 28;
  localparam int TGT_HI = 24;
  localparam int TGT_LO = 15;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry in-order holding buffer (output register plus one skid slot) that
// lets decode stall without losing words already requested from memory.
module fetch_skid_buffer #(
  parameter int W = 42
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         stall,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         skid_valid
);

  logic [W-1:0] skid_data;

  // The skid entry is only non-empty while the output is held, so whenever the
  // output advances the skid word goes first to keep program order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || !stall) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= in_valid;
        if (in_valid) skid_data <= in_data;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: pc generation, one-cycle memory latency tracking,
// halt and redirect handling. Optional jump predecode: FETCH_JUMP_PREDECODE_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = DEFAULT_PC_W,
  parameter int              INSTR_W  = DEFAULT_INSTR_W,
  parameter logic [PC_W-1:0] START_PC = PC_W'(1)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               id_stall,
  input  logic               ex_redirect,
  input  logic [PC_W-1:0]    ex_target,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               halted
);

  localparam int ENTRY_W = INSTR_W + PC_W;

  logic                req_valid;
  logic [PC_W-1:0]     req_pc;
  logic                arrival_halt;
  logic                arrival_fwd;
  logic                consume;
  logic                skid_valid;
  logic [2:0]          occupancy;
  logic                issue_en;
  logic                take_jump;
  logic [PC_W-1:0]     jump_target;
  logic [ENTRY_W-1:0]  out_data;

  assign arrival_halt = req_valid && (instruction == INSTR_W'(HALT_WORD));
  assign arrival_fwd  = req_valid && !arrival_halt;
  assign consume      = if_valid && !id_stall;

  // Words that will still need a slot next cycle, including the one arriving now.
  assign occupancy = 3'(if_valid) + 3'(skid_valid) + 3'(req_valid) - 3'(consume);
  assign issue_en  = !halted && (occupancy < 3'd2);

`ifdef FETCH_JUMP_PREDECODE_EN
  assign take_jump   = arrival_fwd && (instruction[OP_HI:OP_LO] == OP_JUMP);
  assign jump_target = PC_W'(instruction[TGT_HI:TGT_LO]);
`else
  assign take_jump   = 1'b0;
  assign jump_target = '0;
`endif

  // Redirect outranks halt, which outranks jump; halt and jump both squash
  // the request that would otherwise issue on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= START_PC;
      req_valid <= 1'b0;
      req_pc    <= '0;
      halted    <= 1'b0;
    end else if (ex_redirect) begin
      pc        <= ex_target;
      req_valid <= 1'b0;
      halted    <= 1'b0;
    end else if (arrival_halt) begin
      pc        <= req_pc;
      req_valid <= 1'b0;
      halted    <= 1'b1;
    end else if (take_jump) begin
      pc        <= jump_target;
      req_valid <= 1'b0;
    end else if (issue_en) begin
      req_valid <= 1'b1;
      req_pc    <= pc;
      pc        <= pc + PC_W'(1);
    end else begin
      req_valid <= 1'b0;
    end
  end

  fetch_skid_buffer #(
    .W(ENTRY_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (ex_redirect),
    .in_valid  (arrival_fwd),
    .in_data   ({instruction, req_pc}),
    .stall     (id_stall),
    .out_valid (if_valid),
    .out_data  (out_data),
    .skid_valid(skid_valid)
  );

  assign {if_instr, if_pc} = out_data;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a program-flow walk of the memory image
// predicts the delivered {pc, instr} stream, a negedge monitor checks it.
module tb_fetch_unit;

  localparam logic [31:0] HALT       = 32'hFFFF_FFFF;
  localparam logic [31:0] JUMP_TO_17 = 32'hC008_8000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  pc;
  logic [31:0] instruction = '0;
  logic        id_stall = 1'b0;
  logic        ex_redirect = 1'b0;
  logic [9:0]  ex_target = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [9:0]  if_pc;
  logic        halted;

  fetch_unit #(.START_PC(10'd1)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .instruction(instruction),
    .id_stall   (id_stall),
    .ex_redirect(ex_redirect),
    .ex_target  (ex_target),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  always @(posedge clk) instruction <= mem[pc];

  int          vectors = 0;
  int          miscompares = 0;
  logic [41:0] exp_q[$];
  logic        exp_halt = 1'b0;
  logic [9:0]  exp_halt_pc = '0;
  logic        hold_prev = 1'b0;
  logic [42:0] hold_snap = '0;
  logic [9:0]  frozen_pc;
  int          waited;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Follow program flow from start: sequential words, predecoded jumps, stop at halt.
  function automatic void build_expected(input logic [9:0] start);
    logic [9:0]  p;
    logic [31:0] w;
    p = start;
    exp_q.delete();
    exp_halt    = 1'b0;
    exp_halt_pc = '0;
    for (int i = 0; i < 600; i++) begin
      w = mem[p];
      if (w == HALT) begin
        exp_halt    = 1'b1;
        exp_halt_pc = p;
        break;
      end
      exp_q.push_back({p, w});
      p = p + 10'd1;
`ifdef FETCH_JUMP_PREDECODE_EN
      if (w[31:28] == 4'hC) p = w[24:15];
`endif
    end
  endfunction

  function automatic logic [31:0] safe_word();
    logic [31:0] w;
    do w = $urandom; while (w[31:28] == 4'hC || w == HALT);
    return w;
  endfunction

  task automatic loadImage();
    for (int i = 0; i < 1024; i++) mem[i] = safe_word();
    mem[0] = HALT;
  endtask

  task automatic applyStimulus(input logic stall, input logic redir, input logic [9:0] tgt);
    id_stall    = stall;
    ex_redirect = redir;
    ex_target   = tgt;
    @(posedge clk);
    if (redir) build_expected(tgt);
    #1;
    ex_redirect = 1'b0;
  endtask

  task automatic runRandom(input int cycles, input int stall_pct);
    for (int i = 0; i < cycles; i++)
      applyStimulus($urandom_range(99) < 32'(stall_pct), 1'b0, 10'd0);
  endtask

  task automatic finishReset();
    id_stall    = 1'b0;
    ex_redirect = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    build_expected(10'd1);
  endtask

  // Monitor: every consumed word must be the next predicted one; held outputs must not move.
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev)
        checkOutput("stall_hold", 64'({if_valid, if_pc, if_instr}), 64'(hold_snap));
      if (if_valid && !id_stall) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_word: got pc %0h instr %0h, expected no output", if_pc, if_instr);
        end else begin
          checkOutput("stream", 64'({if_pc, if_instr}), 64'(exp_q.pop_front()));
        end
      end
      hold_prev = if_valid && id_stall && !ex_redirect;
      hold_snap = {if_valid, if_pc, if_instr};
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    loadImage();
    mem[24] = HALT;
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_pc", 64'(pc), 64'(10'd1));
    checkOutput("reset_if_valid", 64'(if_valid), 64'(0));
    checkOutput("reset_if_instr", 64'(if_instr), 64'(0));
    checkOutput("reset_if_pc", 64'(if_pc), 64'(0));
    checkOutput("reset_halted", 64'(halted), 64'(0));
    finishReset();

    // Latency and stall hold
    applyStimulus(1'b0, 1'b0, 10'd0);
    checkOutput("issue_edge1_pc", 64'(pc), 64'(10'd2));
    checkOutput("edge1_if_valid", 64'(if_valid), 64'(0));
    applyStimulus(1'b0, 1'b0, 10'd0);
    checkOutput("issue_edge2_pc", 64'(pc), 64'(10'd3));
    checkOutput("edge2_out", 64'({if_valid, if_pc}), 64'({1'b1, 10'd1}));
    applyStimulus(1'b0, 1'b0, 10'd0);
    applyStimulus(1'b0, 1'b0, 10'd0);
    checkOutput("word3_out", 64'({if_valid, if_pc}), 64'({1'b1, 10'd3}));
    applyStimulus(1'b1, 1'b0, 10'd0);
    frozen_pc = pc;
    applyStimulus(1'b1, 1'b0, 10'd0);
    applyStimulus(1'b1, 1'b0, 10'd0);
    checkOutput("stall_if_pc", 64'(if_pc), 64'(10'd3));
    checkOutput("stall_pc_frozen", 64'(pc), 64'(frozen_pc));
    for (int k = 4; k <= 6; k++) begin
      applyStimulus(1'b0, 1'b0, 10'd0);
      checkOutput("release_seq", 64'({if_valid, if_pc}), 64'({1'b1, 10'(k)}));
    end

    // Run into the halt word at 24
    waited = 0;
    while (!halted && waited < 60) begin
      applyStimulus($urandom_range(99) < 30, 1'b0, 10'd0);
      waited++;
    end
    checkOutput("halt_reached", 64'(halted), 64'(1));
    checkOutput("halt_pc", 64'(pc), 64'(exp_halt_pc));
    repeat (4) applyStimulus(1'b0, 1'b0, 10'd0);
    checkOutput("halt_drained", 64'(exp_q.size()), 64'(0));
    checkOutput("halt_no_output", 64'(if_valid), 64'(0));

    // Redirect out of halt
    applyStimulus(1'b0, 1'b1, 10'd17);
    checkOutput("redirect_clears_halt", 64'(halted), 64'(0));
    applyStimulus(1'b0, 1'b0, 10'd0);
    checkOutput("redirect_bubble", 64'(if_valid), 64'(0));
    applyStimulus(1'b0, 1'b0, 10'd0);
    checkOutput("redirect_latency", 64'({if_valid, if_pc}), 64'({1'b1, 10'd17}));
    runRandom(20, 30);

    // Redirect while stalled with a full buffer
    applyStimulus(1'b0, 1'b1, 10'd100);
    runRandom(10, 20);
    repeat (3) applyStimulus(1'b1, 1'b0, 10'd0);
    applyStimulus(1'b1, 1'b1, 10'd300);
    checkOutput("flush_if_valid", 64'(if_valid), 64'(0));
    applyStimulus(1'b0, 1'b0, 10'd0);
    checkOutput("flush_bubble", 64'(if_valid), 64'(0));
    applyStimulus(1'b0, 1'b0, 10'd0);
    checkOutput("flush_target", 64'({if_valid, if_pc}), 64'({1'b1, 10'd300}));
    runRandom(15, 30);

    // Jump image: word 23 jumps to 17, halt at 25
    rst = 1'b1;
    loadImage();
    mem[23] = JUMP_TO_17;
    mem[25] = HALT;
    finishReset();
    runRandom(40, 30);
    runRandom(40, 0);
`ifdef FETCH_JUMP_PREDECODE_EN
    checkOutput("jump_loop_no_halt", 64'(halted), 64'(0));
`else
    checkOutput("plain_halt", 64'(halted), 64'(1));
    checkOutput("plain_halt_pc", 64'(pc), 64'(10'd25));
    checkOutput("plain_drained", 64'(exp_q.size()), 64'(0));
`endif

    // pc wrap at 1023
    rst = 1'b1;
    loadImage();
    mem[0] = safe_word();
    finishReset();
    applyStimulus(1'b0, 1'b1, 10'd1021);
    repeat (3) applyStimulus(1'b0, 1'b0, 10'd0);
    checkOutput("pc_wrap", 64'(pc), 64'(10'd0));
    runRandom(10, 30);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_if_valid", 64'(if_valid), 64'(0));
    checkOutput("async_rst_pc", 64'(pc), 64'(10'd1));
    checkOutput("async_rst_if_pc", 64'({if_pc, if_instr}), 64'(0));
    checkOutput("async_rst_halted", 64'(halted), 64'(0));
    finishReset();
    applyStimulus(1'b0, 1'b0, 10'd0);
    checkOutput("restart_issue", 64'(pc), 64'(10'd2));
    runRandom(20, 30);
    repeat (3) applyStimulus(1'b0, 1'b0, 10'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
